// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
//
// Drives a multiplexed common-anode 7-segment display (up to 8 digits) with
// a hex value.  The value is captured on a one-cycle load strobe into a
// pending register and only moved into the displayed register at a frame
// boundary.  Because of this, a frame never mixes digits from two values.
// Each digit slot begins with a blanking gap, with all anodes off, so the
// previous digit's segments do not ghost onto the next digit.
//
// Parameters
//   DIGITS       number of digits (1..8); value width is 4*DIGITS
//   SCAN_CYCLES  clock cycles per digit slot, gap included
//   GAP_CYCLES   cycles at the start of each slot with all anodes off
//                (0 <= GAP_CYCLES < SCAN_CYCLES)
//   LZ_BLANK     1 = blank leading zero digits (digit 0 always shows)
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   value       in   4*DIGITS  value to display; nibble k -> digit k (0 = rightmost)
//   dp_mask     in   DIGITS    decimal-point enables, captured with value
//   load        in   one-cycle strobe capturing value and dp_mask
//   an          out  DIGITS    digit enables, active-low
//   seg         out  7         segments, active-low, seg[0]=a .. seg[6]=g
//   dp          out  decimal point, active-low
//   frame_done  out  one-cycle pulse in the first cycle of each frame
// ---------------------------------------------------------------------------
module seg7_scan #(
    parameter int DIGITS      = 8,
    parameter int SCAN_CYCLES = 1000,
    parameter int GAP_CYCLES  = 10,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Hex digit to active-high segment pattern, bit order gfedcba.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan state
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;

    // Displayed and pending values
    logic [4*DIGITS-1:0] shown;
    logic [DIGITS-1:0]   shown_dp;
    logic [4*DIGITS-1:0] pend;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_v;

    // Next-state values
    logic                cnt_wrap;
    logic                idx_wrap;
    logic                boundary;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [IDX_W-1:0]    idx_nxt;
    logic [4*DIGITS-1:0] shown_nxt;
    logic [DIGITS-1:0]   shown_dp_nxt;
    logic [4*DIGITS-1:0] pend_nxt;
    logic [DIGITS-1:0]   pend_dp_nxt;
    logic                pend_v_nxt;

    // Output next-state values
    logic [DIGITS-1:0]   lz;
    logic                upper_zero;
    logic                show;
    logic [3:0]          nib;
    logic                nib_dp;
    logic                nib_blank;
    logic [DIGITS-1:0]   an_nxt;
    logic [6:0]          seg_nxt;
    logic                dp_nxt;

    // Counters and value commit
    always_comb begin
        cnt_wrap = (cnt == CNT_LAST);
        idx_wrap = (idx == IDX_LAST);
        boundary = cnt_wrap && idx_wrap;

        cnt_nxt = cnt_wrap ? '0 : cnt + 1'b1;
        idx_nxt = idx;
        if (cnt_wrap) begin
            idx_nxt = idx_wrap ? '0 : idx + 1'b1;
        end

        shown_nxt    = shown;
        shown_dp_nxt = shown_dp;
        pend_nxt     = pend;
        pend_dp_nxt  = pend_dp;
        pend_v_nxt   = pend_v;

        if (boundary) begin
            // A load landing on the boundary edge itself goes straight to
            // the display so it is not held back a whole extra frame.
            if (load) begin
                shown_nxt    = value;
                shown_dp_nxt = dp_mask;
                pend_nxt     = value;
                pend_dp_nxt  = dp_mask;
            end else if (pend_v) begin
                shown_nxt    = pend;
                shown_dp_nxt = pend_dp;
            end
            pend_v_nxt = 1'b0;
        end else if (load) begin
            pend_nxt    = value;
            pend_dp_nxt = dp_mask;
            pend_v_nxt  = 1'b1;
        end
    end

    // Output decode, taken from next-state so that the registered outputs
    // line up with the counters and value registers in the same cycle.
    always_comb begin
        // A digit is a leading zero when it and every digit above it are 0.
        upper_zero = 1'b1;
        lz         = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (shown_nxt[4*k +: 4] == 4'h0);
            lz[k]      = LZ_BLANK && (k != 0) && upper_zero;
        end

        show      = (cnt_nxt >= GAP_END);
        nib       = 4'h0;
        nib_dp    = 1'b0;
        nib_blank = 1'b0;
        an_nxt    = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_nxt == IDX_W'(k)) begin
                nib       = shown_nxt[4*k +: 4];
                nib_dp    = shown_dp_nxt[k];
                nib_blank = lz[k];
                an_nxt[k] = ~show;
            end
        end

        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (show) begin
            // Blanked leading zeros keep their anode and decimal point.
            seg_nxt = nib_blank ? 7'h7F : ~hex_to_seg(nib);
            dp_nxt  = ~nib_dp;
        end
    end

    // Register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            shown      <= '0;
            shown_dp   <= '0;
            pend       <= '0;
            pend_dp    <= '0;
            pend_v     <= 1'b0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shown      <= shown_nxt;
            shown_dp   <= shown_dp_nxt;
            pend       <= pend_nxt;
            pend_dp    <= pend_dp_nxt;
            pend_v     <= pend_v_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            // The cycle after a boundary edge is cnt=0, idx=0.
            frame_done <= boundary;
        end
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Output-side counterpart to the button debouncer: drives board user-visible I/O (8-digit multiplexed 7-segment display) instead of sampling it.
- Shows a 32-bit CPU value (PC, register, or memory word) as hex.
- Value is latched on a load strobe and committed only at frame boundaries, so the display never shows half of one value and half of another.
- Inter-digit blanking gap suppresses ghosting.

Parameters:
- DIGITS, 8, number of digits (1..8); value width is 4*DIGITS.
- SCAN_CYCLES, 1000, clock cycles per digit slot, gap included.
- GAP_CYCLES, 10, cycles at the start of each slot with all anodes off; requires 0 <= GAP_CYCLES < SCAN_CYCLES.
- LZ_BLANK, 1, 1 = blank leading zero digits (digit 0 is never blanked).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*DIGITS  value to display; nibble k goes to digit k (digit 0 = rightmost).
- dp_mask  in  DIGITS  decimal-point enables; latched together with value.
- load  in  1  one-cycle strobe; captures value and dp_mask.
- an  out  DIGITS  digit enables, active-low.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: an all 1, seg=7'h7F, dp=1, frame_done=0.
  - Internal state: cnt=0, idx=0, shown=0, shown_dp=0, pend=0, pend_dp=0, pend_v=0.
  - Reset taking effect mid-slot forces the outputs off immediately, without waiting for a clock edge.
- Internal counters:
  - cnt counts 0..SCAN_CYCLES-1 and wraps to 0.
  - On that wrap, idx advances 0..DIGITS-1 and wraps to 0.
  - A frame boundary is the edge where idx wraps DIGITS-1 -> 0.
- Outputs are flops with no combinational path from inputs. In any cycle they correspond to the same-cycle cnt/idx/shown registers, so they are computed from next-state.
- Gap phase (cnt < GAP_CYCLES): an all 1, seg=7'h7F, dp=1.
- Show phase (cnt >= GAP_CYCLES):
  - an has only bit idx = 0.
  - seg = ~hex(shown nibble idx).
  - dp = ~shown_dp[idx].
- hex() table, active-high gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Leading-zero blanking (LZ_BLANK=1):
  - Digit k>0 shows seg=7'h7F when all nibbles k..DIGITS-1 of shown are 0.
  - The anode is still enabled and dp is still driven from shown_dp.
  - Digit 0 always displays.
- Load handling:
  - load=1 sets pend<=value, pend_dp<=dp_mask, pend_v<=1.
  - Multiple loads within one frame: last one wins.
- Commit at frame boundary:
  - If pend_v: shown<=pend, shown_dp<=pend_dp, pend_v<=0.
  - If load=1 on the boundary edge itself: value/dp_mask bypass straight into shown/shown_dp, and pend_v ends at 0.
  - No load: shown holds indefinitely.
- frame_done = 1 exactly in the cycle where cnt=0 and idx=0, excluding the first cycle after reset.
  - Period is DIGITS*SCAN_CYCLES cycles.
- The first frame after reset displays shown=0: digit 0 shows "0", other digits are blanked if LZ_BLANK.
- Target size: roughly 150–250 lines of RTL.

Test Plan (DIGITS=8, SCAN_CYCLES=8, GAP_CYCLES=2, LZ_BLANK=1):
- Reset release, no load -> an=FF for cnt 0–1 of each slot. During cnt 2–7: slot 0 gives an=FE, seg=40 (0); slots 1–7 give seg=7F. frame_done every 64 cycles starting at cycle 64.
- load value=0x12345678, dp_mask=0x01 mid-frame 0 -> frame 0 unchanged. Frame 1: digit0 seg=00 (8) dp=0; digit7 seg=79 (1); digit1 seg=78 (7).
- load 0x000000A0 -> next frame: digit0 seg=40, digit1 seg=08 (A), digits 2–7 seg=7F with their an still pulsing low.
- Two loads in one frame, 0x11111111 then 0x0000BEEF -> next frame shows only BEEF: digit3 seg=03, digit2 seg=06, digit1 seg=06, digit0 seg=0E.
- load 0x5 in exact boundary cycle -> frame starting that cycle shows digit0 seg=12 (5); no extra-frame delay.
- Assert rst_n=0 during show phase of digit 3 -> an=FF, seg=7F, dp=1 before next clk edge. After release, shown=0 and scanning restarts at idx=0, cnt=0.
